// File: rtl/vx_cache_pkg.sv
// Shared definitions for the cache request serializer: lane-index width helper and default sizes.
// Used by vx_rr_arbiter and vx_cache_req_serializer.
package vx_cache_pkg;

   // Width of a lane index; a single lane still gets one (constant-zero) bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_NUM_REQS   = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_TAG_WIDTH  = 8;

   // Request payload at the default sizes; the serializer declares its own
   // copy sized from its parameters so non-default instances stay consistent.
   typedef struct packed {
      logic                        rw;
      logic [DEF_DATA_WIDTH/8-1:0] byteen;
      logic [DEF_ADDR_WIDTH-1:0]   addr;
      logic [DEF_DATA_WIDTH-1:0]   data;
      logic [DEF_TAG_WIDTH-1:0]    tag;
   } req_payload_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting lane scanning cyclically from rr_ptr_i.
// The pointer register lives in the parent.
import vx_cache_pkg::*;

module vx_rr_arbiter #(
   parameter int NUM_REQS = 4,
   parameter int LANE_W   = clog2_min1(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] req_i,
   input  logic [LANE_W-1:0]   rr_ptr_i,
   output logic [NUM_REQS-1:0] grant_oh_o,
   output logic [LANE_W-1:0]   grant_idx_o,
   output logic                any_valid_o
);

   logic [LANE_W-1:0] lane;

   // Offset i from the pointer is checked in order, so the earliest hit wins.
   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_valid_o = 1'b0;
      lane        = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         lane = LANE_W'((int'(rr_ptr_i) + i) % NUM_REQS);
         if (!any_valid_o && req_i[lane]) begin
            any_valid_o      = 1'b1;
            grant_oh_o[lane] = 1'b1;
            grant_idx_o      = lane;
         end
      end
   end

endmodule

// File: rtl/vx_cache_req_serializer.sv
// Serialises a multi-lane request bundle round-robin into one registered request per cycle,
// appending the source lane to the tag. Optional perf counters under VX_CACHE_REQ_SER_PERF_EN.
import vx_cache_pkg::*;

module vx_cache_req_serializer #(
   parameter int NUM_REQS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 8,
   parameter int DATA_SIZE  = DATA_WIDTH / 8,
   parameter int LANE_W     = clog2_min1(NUM_REQS),
   parameter int OTAG_W     = TAG_WIDTH + LANE_W
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_REQS-1:0]                  req_valid_i,
   input  logic [NUM_REQS-1:0]                  req_rw_i,
   input  logic [NUM_REQS-1:0][DATA_SIZE-1:0]   req_byteen_i,
   input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  req_data_i,
   input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag_i,
   output logic [NUM_REQS-1:0]                  req_ready_o,
   output logic                                 mem_valid_o,
   output logic                                 mem_rw_o,
   output logic [DATA_SIZE-1:0]                 mem_byteen_o,
   output logic [ADDR_WIDTH-1:0]                mem_addr_o,
   output logic [DATA_WIDTH-1:0]                mem_data_o,
   output logic [OTAG_W-1:0]                    mem_tag_o,
   input  logic                                 mem_ready_i
`ifdef VX_CACHE_REQ_SER_PERF_EN
   ,
   output logic [31:0]                          perf_issued_o,
   output logic [31:0]                          perf_stall_o
`endif
);

   typedef struct packed {
      logic                  rw;
      logic [DATA_SIZE-1:0]  byteen;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [OTAG_W-1:0]     tag;
   } slot_t;

   slot_t             slot_q, slot_d;
   logic              mem_valid_q, mem_valid_d;
   logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [NUM_REQS-1:0] grant_oh;
   logic [LANE_W-1:0]   grant_idx;
   logic                any_valid;
   logic                slot_free;
   logic                load;

   vx_rr_arbiter #(
      .NUM_REQS (NUM_REQS),
      .LANE_W   (LANE_W)
   ) u_arb (
      .req_i       (req_valid_i),
      .rr_ptr_i    (rr_ptr_q),
      .grant_oh_o  (grant_oh),
      .grant_idx_o (grant_idx),
      .any_valid_o (any_valid)
   );

   // A slot being drained this cycle may be refilled in the same cycle.
   assign slot_free = !mem_valid_q || mem_ready_i;
   assign load      = slot_free && any_valid;

   assign req_ready_o = (rst_ni && load) ? grant_oh : '0;

   always_comb begin
      slot_d      = slot_q;
      mem_valid_d = mem_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (slot_free) begin
         mem_valid_d = any_valid;
         if (any_valid) begin
            slot_d.rw     = req_rw_i[grant_idx];
            slot_d.byteen = req_byteen_i[grant_idx];
            slot_d.addr   = req_addr_i[grant_idx];
            slot_d.data   = req_data_i[grant_idx];
            slot_d.tag    = {grant_idx, req_tag_i[grant_idx]};
            rr_ptr_d      = (grant_idx == LANE_W'(NUM_REQS - 1)) ? '0
                                                                 : LANE_W'(grant_idx + 1'b1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         slot_q      <= '0;
         mem_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         slot_q      <= slot_d;
         mem_valid_q <= mem_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign mem_valid_o  = mem_valid_q;
   assign mem_rw_o     = slot_q.rw;
   assign mem_byteen_o = slot_q.byteen;
   assign mem_addr_o   = slot_q.addr;
   assign mem_data_o   = slot_q.data;
   assign mem_tag_o    = slot_q.tag;

`ifdef VX_CACHE_REQ_SER_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Both counters wrap naturally at 32 bits.
   always_comb begin
      perf_issued_d = perf_issued_q;
      perf_stall_d  = perf_stall_q;
      if (mem_valid_q && mem_ready_i) begin
         perf_issued_d = perf_issued_q + 32'd1;
      end
      if (mem_valid_q && !mem_ready_i) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_issued_o = perf_issued_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule
